key_event_decoder: RTL and testbench

Classifies debounced key activity into short-press, long-press, auto-repeat and double-click events for the Ping-Pong GameBox. Sits directly downstream of the per-key debounce stage, one instance per player key. Emits one-cycle event strobes to the game-control FSM (serve, pause, menu).

---
 rtl/gamebox_pkg.sv | 11 +
 rtl/key_event_decoder.sv | 90 +++++++++
 tb/tb_key_event_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gamebox_pkg.sv
// gamebox_pkg: shared key-decoder FSM encoding and default 50 MHz timing constants
package gamebox_pkg;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRESS1   = 3'd1;
    localparam logic [2:0] WAIT_GAP = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] WAIT_REL = 3'd4;
    localparam int LONG_CYC_50M    = 50_000_000;
    localparam int DBL_GAP_CYC_50M = 15_000_000;
    localparam int REPEAT_CYC_50M  = 10_000_000;
endpackage

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key activity into short/long/repeat/double strobes
module key_event_decoder
    import gamebox_pkg::*;
#(
    parameter int LONG_CYC    = LONG_CYC_50M,
    parameter int DBL_GAP_CYC = DBL_GAP_CYC_50M,
    parameter int REPEAT_CYC  = REPEAT_CYC_50M
) (
    input  logic clk,
    input  logic rst,
    input  logic key_stable,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic double_pulse,
    output logic busy
);
    localparam int MAX_CYC = (LONG_CYC > DBL_GAP_CYC) ? ((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC)
                                                      : ((DBL_GAP_CYC > REPEAT_CYC) ? DBL_GAP_CYC : REPEAT_CYC);
    localparam int CNT_W = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             key_q;
    logic             press_edge;

    // key_q resets to "pressed" so a key held through reset must be released first
    assign press_edge = key_q & ~key_stable;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            key_q <= 1'b0;
        end else begin
            key_q <= key_stable;
            case (state)
                IDLE: if (press_edge) begin
                    state <= PRESS1;
                    cnt   <= '0;
                end
                PRESS1: if (key_stable) begin
                    state <= WAIT_GAP;
                    cnt   <= '0;
                end else if (cnt == LONG_LAST) begin
                    state <= HOLD;
                    cnt   <= '0;
                end else cnt <= cnt + CNT_W'(1);
                WAIT_GAP: if (!key_stable) begin
                    state <= WAIT_REL;
                    cnt   <= '0;
                end else if (cnt == GAP_LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + CNT_W'(1);
                HOLD: if (key_stable) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else cnt <= (cnt == REP_LAST) ? '0 : cnt + CNT_W'(1);
                WAIT_REL: if (key_stable) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // strobes mirror the transition conditions above; a second press beats the gap timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            double_pulse <= 1'b0;
        end else begin
            short_pulse  <= state == WAIT_GAP && key_stable && cnt == GAP_LAST;
            long_pulse   <= state == PRESS1 && !key_stable && cnt == LONG_LAST;
            repeat_pulse <= state == HOLD && !key_stable && cnt == REP_LAST;
            double_pulse <= state == WAIT_GAP && !key_stable;
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed scoreboard bench for key_event_decoder (L=20, gap=8, repeat=5)
module tb_key_event_decoder;
    localparam logic [3:0] SHORT = 4'b0001, LONG = 4'b0010, REP = 4'b0100, DBL = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_stable = 1'b1;
    logic short_pulse, long_pulse, repeat_pulse, double_pulse, busy;
    logic [4:0] outs;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int p, r, r2;
    ev_t exp_q[$];

    key_event_decoder #(.LONG_CYC(20), .DBL_GAP_CYC(8), .REPEAT_CYC(5)) dut (
        .clk(clk),
        .rst(rst),
        .key_stable(key_stable),
        .short_pulse(short_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .double_pulse(double_pulse),
        .busy(busy)
    );

    assign outs = {busy, double_pulse, repeat_pulse, long_pulse, short_pulse};

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // every strobe seen must match the oldest expected event in kind and cycle
    always @(negedge clk) begin
        if (!rst && outs[3:0] != 4'b0000) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_strobe observed=%b@%0d expected=none", outs[3:0], cyc);
            end
            if (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                tests++;
                assert (outs[3:0] === e.mask && cyc == e.cyc) else begin
                    fails++;
                    $error("FAIL strobe observed=%b@%0d expected=%b@%0d", outs[3:0], cyc, e.mask, e.cyc);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] m);
        ev_t e;
        e.cyc = c;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [4:0] expv);
        tests++;
        assert (outs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, expv);
        end
    endtask

    task automatic check_empty(input string tag);
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s pending_events observed=%0d expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 5'b00000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // short press: 5 held cycles, report 8 cycles after release
        key_stable = 1'b0; p = cyc + 1;
        wait_to(p); check("short_busy", 5'b10000);
        wait_to(p + 4); key_stable = 1'b1; r = cyc + 1; push(r + 8, SHORT);
        wait_to(r + 7); check("short_pre", 5'b10000);
        wait_to(r + 8); check("short_done", 5'b00001);
        wait_to(r + 10); check_empty("short_q");
        // long press with four repeats
        key_stable = 1'b0; p = cyc + 1;
        push(p + 20, LONG); push(p + 25, REP); push(p + 30, REP); push(p + 35, REP); push(p + 40, REP);
        wait_to(p + 20); check("long", 5'b10010);
        wait_to(p + 40); check("repeat4", 5'b10100);
        key_stable = 1'b1;
        wait_to(p + 41); check("long_release", 5'b00000);
        wait_to(p + 50); check_empty("long_q");
        // double click, then a long hold that must not turn into a long press
        key_stable = 1'b0; p = cyc + 1;
        wait_to(p + 2); key_stable = 1'b1; r = cyc + 1;
        wait_to(r + 3); key_stable = 1'b0; push(r + 4, DBL);
        wait_to(r + 4); check("double", 5'b11000);
        wait_to(r + 54); check("double_hold", 5'b10000);
        key_stable = 1'b1;
        wait_to(r + 55); check("double_release", 5'b00000);
        wait_to(r + 58); check_empty("double_q");
        // second press exactly 8 cycles after release
        key_stable = 1'b0; p = cyc + 1;
        wait_to(p + 1); key_stable = 1'b1; r = cyc + 1;
        wait_to(r + 7); key_stable = 1'b0; push(r + 8, DBL);
        wait_to(r + 8); check("gap8_double", 5'b11000);
        key_stable = 1'b1;
        wait_to(r + 9); check("gap8_release", 5'b00000);
        wait_to(r + 12); check_empty("gap8_q");
        // second press 9 cycles after release: short, then a fresh press
        key_stable = 1'b0; p = cyc + 1;
        wait_to(p + 1); key_stable = 1'b1; r = cyc + 1; push(r + 8, SHORT);
        wait_to(r + 8); check("gap9_short", 5'b00001);
        key_stable = 1'b0;
        wait_to(r + 9); check("gap9_press1", 5'b10000);
        key_stable = 1'b1; r2 = cyc + 1; push(r2 + 8, SHORT);
        wait_to(r2 + 8); check("gap9_short2", 5'b00001);
        wait_to(r2 + 10); check_empty("gap9_q");
        // release sampled at the 20th held edge stays on the short path
        key_stable = 1'b0; p = cyc + 1;
        wait_to(p + 19); key_stable = 1'b1; r = cyc + 1; push(r + 8, SHORT);
        wait_to(r); check("long_boundary", 5'b10000);
        wait_to(r + 8); check("long_boundary_short", 5'b00001);
        wait_to(r + 10); check_empty("boundary_q");
        // asynchronous reset while long_pulse is high, key held through reset
        key_stable = 1'b0; p = cyc + 1; push(p + 20, LONG);
        wait_to(p + 20);
        #3 rst = 1'b1;
        #1 check("reset_async", 5'b00000);
        wait_to(p + 23); rst = 1'b0;
        wait_to(p + 24); check("reset_released", 5'b00000);
        wait_to(p + 53); check("reset_held_key", 5'b00000);
        check_empty("reset_q");
        key_stable = 1'b1;
        wait_to(p + 56); key_stable = 1'b0; p = cyc + 1;
        wait_to(p); check("repress_busy", 5'b10000);
        wait_to(p + 1); key_stable = 1'b1; r = cyc + 1; push(r + 8, SHORT);
        wait_to(r + 8); check("repress_short", 5'b00001);
        wait_to(r + 10); check_empty("final_q");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
